// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and defaults for the fifo_reader block.
//   fifo_reader_state_t : read FSM state (IDLE = nothing in flight,
//                         PEND = strobe issued last cycle, data arrives now)
//   DEF_WIDTH           : default data width
//   DEF_BUF_DEPTH       : default internal buffer depth
//   STATS_W             : width of the optional transfer counter
package fifo_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } fifo_reader_state_t;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_BUF_DEPTH = 2;
  localparam int unsigned STATS_W       = 32;

endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: small circular buffer holding bytes read from the FIFO
// until the downstream consumer accepts them.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (pointers and count)
//   clr_i   : synchronous clear, same effect as reset on control state
//   push_i  : write dat_i at the tail (caller guarantees space)
//   pop_i   : advance the head (caller guarantees count_o != 0)
//   dat_i   : write data
//   dat_o   : head entry
//   count_o : number of valid entries, 0..DEPTH
module fifo_reader_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           dat_i,
  output logic [WIDTH-1:0]           dat_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= dat_i;
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the team's fifo block. Pops the FIFO
// read port (data valid one cycle after the strobe) and re-presents the bytes
// as a strobe/acknowledge stream with back-pressure.
//   clk_i      : clock (FIFO read clock)
//   rst_i      : synchronous active-high reset
//   enable_i   : allows new FIFO strobes
//   flush_i    : drops buffered and in-flight data
//   rd_stb_o   : FIFO pop strobe
//   rd_empty_i : FIFO empty flag
//   rd_dat_i   : FIFO read data, valid the cycle after rd_stb_o
//   out_stb_o  : output data valid
//   out_ack_i  : consumer accepts out_dat_o
//   out_dat_o  : output data (buffer head, zero when empty)
//   bytes_o    : completed output transfers (only with FIFO_READER_STATS_EN)
// Optional feature macro: FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               flush_i,
  output logic               rd_stb_o,
  input  logic               rd_empty_i,
  input  logic [WIDTH-1:0]   rd_dat_i,
  output logic               out_stb_o,
  input  logic               out_ack_i,
  output logic [WIDTH-1:0]   out_dat_o
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [STATS_W-1:0] bytes_o
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fifo_reader_state_t state_q, state_d;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   used;
  logic [WIDTH-1:0]   head_dat;
  logic               push;
  logic               pop;

  // Space already promised includes the byte still in flight.
  assign used = count + CNT_W'(state_q == PEND);

  assign rd_stb_o = enable_i && !rd_empty_i && (state_q == IDLE) && !flush_i &&
                    (used < CNT_W'(BUF_DEPTH));

  assign out_stb_o = (count != '0);
  assign out_dat_o = out_stb_o ? head_dat : '0;

  assign push = (state_q == PEND) && !flush_i;
  assign pop  = out_stb_o && out_ack_i && !flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_stb_o) state_d = PEND;
      PEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe stage -> capture stage: FIFO data lands one cycle after rd_stb_o.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .dat_i   (rd_dat_i),
    .dat_o   (head_dat),
    .count_o (count)
  );

`ifdef FIFO_READER_STATS_EN
  logic [STATS_W-1:0] bytes_q;

  // Only reset clears the counter; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i)    bytes_q <= '0;
    else if (pop) bytes_q <= bytes_q + STATS_W'(1);
  end

  assign bytes_o = bytes_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BUF_DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             enable_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             rd_stb_o;
  logic             rd_empty_i = 1'b1;
  logic [WIDTH-1:0] rd_dat_i = '0;
  logic             out_stb_o;
  logic             out_ack_i = 1'b0;
  logic [WIDTH-1:0] out_dat_o;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]      bytes_o;
`endif

  fifo_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .flush_i    (flush_i),
    .rd_stb_o   (rd_stb_o),
    .rd_empty_i (rd_empty_i),
    .rd_dat_i   (rd_dat_i),
    .out_stb_o  (out_stb_o),
    .out_ack_i  (out_ack_i),
    .out_dat_o  (out_dat_o)
`ifdef FIFO_READER_STATS_EN
    ,
    .bytes_o    (bytes_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO model and reference model state.
  logic [WIDTH-1:0] fq[$];        // bytes held in the external FIFO
  logic [WIDTH-1:0] mb[$];        // bytes expected in the reader buffer
  logic [WIDTH-1:0] got[$];       // bytes actually transferred out
  bit               m_inflight = 0;
  logic [WIDTH-1:0] m_inflight_dat = '0;
  bit               pend_valid = 0;
  logic [WIDTH-1:0] pend_dat = '0;
  int unsigned      m_bytes = 0;
  int               stb_cnt = 0;
  bit               chk_zero = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One clock cycle: drive inputs at negedge, compare against the model,
  // then advance the model to match the following rising edge.
  task automatic step(input bit en, input bit fl, input bit ack, input bit r);
    bit exp_stb;
    logic [WIDTH-1:0] popped;
    @(negedge clk);
    rst_i      = r;
    enable_i   = en;
    flush_i    = fl;
    out_ack_i  = ack;
    rd_empty_i = (fq.size() == 0);
    rd_dat_i   = pend_valid ? pend_dat : WIDTH'($urandom);
    #1;
    exp_stb = en && (fq.size() != 0) && !m_inflight && !fl && (mb.size() < BUF_DEPTH);
    check("rd_stb", 32'(rd_stb_o), 32'(exp_stb));
    check("out_stb", 32'(out_stb_o), 32'(mb.size() != 0));
    if (mb.size() != 0) check("out_dat", 32'(out_dat_o), 32'(mb[0]));
    if (chk_zero) begin
      check("rst_out_dat", 32'(out_dat_o), 32'h0);
      chk_zero = 0;
    end
`ifdef FIFO_READER_STATS_EN
    check("bytes", bytes_o, m_bytes);
`endif
    if (out_stb_o && ack && !fl && !r) got.push_back(out_dat_o);
    // External FIFO answers the strobe the DUT really issued.
    pend_valid = 0;
    popped = '0;
    if (rd_stb_o) begin
      stb_cnt++;
      if (fq.size() != 0) popped = fq.pop_front();
      pend_dat   = popped;
      pend_valid = 1;
    end
    if (r) begin
      mb.delete();
      m_inflight = 0;
      m_bytes    = 0;
    end else if (fl) begin
      mb.delete();
      m_inflight = 0;
    end else begin
      if (mb.size() != 0 && ack) begin
        void'(mb.pop_front());
        m_bytes++;
      end
      if (m_inflight) mb.push_back(m_inflight_dat);
      m_inflight     = exp_stb;
      m_inflight_dat = popped;
    end
  endtask

  task automatic do_reset();
    fq.delete();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_zero = 1;
  endtask

  initial begin
    int s0;
    bit found;
    logic [WIDTH-1:0] lost_a, lost_b;

    do_reset();
    step(0, 0, 0, 0);

    // Three bytes, consumer always ready.
    got.delete();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    repeat (10) step(1, 0, 1, 0);
    check("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t1_b0", 32'(got[0]), 32'h11);
      check("t1_b1", 32'(got[1]), 32'h22);
      check("t1_b2", 32'(got[2]), 32'h33);
    end

    // Stalled consumer: buffer fills, strobes stop, head held.
    got.delete();
    s0 = stb_cnt;
    for (int i = 0; i < 4; i++) fq.push_back(8'hA0 + 8'(i));
    repeat (8) step(1, 0, 0, 0);
    check("t2_strobes", stb_cnt - s0, 2);
    check("t2_held", 32'(out_dat_o), 32'hA0);
    repeat (12) step(1, 0, 1, 0);
    check("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("t2_order", 32'(got[i]), 32'hA0 + i);

    // Empty FIFO: nothing ever happens.
    s0 = stb_cnt;
    repeat (10) step(1, 0, $urandom_range(0, 1), 0);
    check("t3_no_stb", stb_cnt - s0, 0);

    // Flush while a byte is in flight and one is buffered.
    got.delete();
    for (int i = 0; i < 4; i++) fq.push_back(8'hB0 + 8'(i));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_inflight && mb.size() == 1) found = 1;
      else step(1, 0, 0, 0);
    end
    check("t4_setup", 32'(found), 32'h1);
    lost_a = mb.size() != 0 ? mb[0] : '0;
    lost_b = m_inflight_dat;
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t4_stb_after_flush", 32'(out_stb_o), 32'h0);
    repeat (12) step(1, 0, 1, 0);
    for (int i = 0; i < got.size(); i++) begin
      check("t4_lost_a", 32'(got[i] != lost_a), 32'h1);
      check("t4_lost_b", 32'(got[i] != lost_b), 32'h1);
    end
    check("t4_rest", got.size(), 2);

    // Reset while data is being presented.
    fq.push_back(8'h5C);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mb.size() != 0) found = 1;
      else step(1, 0, 0, 0);
    end
    check("t5_setup", 32'(found), 32'h1);
    fq.delete();
    step(1, 0, 0, 1);
    chk_zero = 1;
    step(1, 0, 0, 0);
    check("t5_rd_stb", 32'(rd_stb_o), 32'h0);
    check("t5_out_stb", 32'(out_stb_o), 32'h0);
    got.delete();
    fq.push_back(8'hA5);
    repeat (6) step(1, 0, 1, 0);
    check("t5_a5_count", got.size(), 1);
    if (got.size() == 1) check("t5_a5", 32'(got[0]), 32'hA5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back(WIDTH'($urandom));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, 0);
    end

`ifdef FIFO_READER_STATS_EN
    do_reset();
    for (int i = 0; i < 256; i++) fq.push_back(WIDTH'(i));
    repeat (600) step(1, 0, 1, 0);
    check("t6_bytes", bytes_o, 32'd256);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    check("t6_bytes_flush", bytes_o, 32'd256);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t6_bytes_rst", bytes_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Single-clock read-side controller for the team's `fifo` block. It drains the FIFO's read port (`rd_stb`/`rd_empty`/`rd_dat`, data valid one cycle after the strobe) and re-presents the bytes as a strobe/acknowledge stream with back-pressure. It sits in the read clock domain, between `fifo` and any downstream consumer. A small internal buffer absorbs the FIFO's one-cycle read latency, so no byte is lost when the consumer stalls.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO data width.
- `BUF_DEPTH`, 2, internal buffer entries; power of two, ≥ 2.

Ports:
- `clk_i`  in  1  clock; connects to the FIFO `rd_clk_i`.
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `enable_i`  in  1  when low, no new FIFO strobes are issued.
- `flush_i`  in  1  discards buffered and in-flight data.
- `rd_stb_o`  out  1  FIFO pop strobe, one cycle wide.
- `rd_empty_i`  in  1  FIFO empty flag.
- `rd_dat_i`  in  WIDTH  FIFO read data; valid the cycle after `rd_stb_o`.
- `out_stb_o`  out  1  output data valid.
- `out_ack_i`  in  1  consumer accepts `out_dat_o`.
- `out_dat_o`  out  WIDTH  output data (buffer head).

## Operation
- State machine has two states:
  - **IDLE**: no read in flight.
  - **PEND**: strobe issued last cycle; `rd_dat_i` is captured this cycle.
- IDLE → PEND when `rd_stb_o` = 1. PEND → IDLE unconditionally after one cycle.
- `rd_stb_o` = `enable_i` && !`rd_empty_i` && state==IDLE && !`flush_i` && (`count` < `BUF_DEPTH`).
  - The strobe is combinational from registered state plus inputs.
  - At most one strobe every two cycles, because the FIFO's empty flag is not valid the cycle after a pop.
- In PEND, `rd_dat_i` is written at the buffer tail, unless `flush_i` is high. This space was reserved at strobe time, counting the in-flight byte: the strobe condition uses `count + (state==PEND)`. In IDLE this equals `count`.
- `out_stb_o` = (`count` != 0). `out_dat_o` = the head entry. A transfer occurs when `out_stb_o` && `out_ack_i`; the head pointer then advances.
- Simultaneous capture and transfer: `count` is unchanged and both pointers advance.
- Pointers are `$clog2(BUF_DEPTH)` bits and wrap naturally. `count` is `$clog2(BUF_DEPTH)+1` bits.
- `flush_i`: at the next edge `count` = 0, pointers = 0, state → IDLE, and any in-flight byte is dropped. A transfer in the same cycle is ignored.
- `enable_i` low mid-PEND: the in-flight byte is still captured.
- `out_ack_i` while `out_stb_o` is low: ignored.

## Timing
- Reset values: `rd_stb_o`=0, `out_stb_o`=0, `out_dat_o`=0, state=IDLE, `count`=0.
- Latency: strobe at edge N → byte captured at edge N+1 → `out_stb_o` high after edge N+1 (2 edges from strobe).
- Sustained throughput with `out_ack_i` tied high: one byte per two cycles.
- Reset mid-operation: synchronous clear as above. An in-flight FIFO byte is lost, so the system must reset the FIFO read side together with this block.
- Output is held stable while `out_stb_o` && !`out_ack_i`.

## Configuration
- `FIFO_READER_STATS_EN` defined: adds port `bytes_o` (out, 32) counting completed output transfers.
  - Wraps at 2^32.
  - Cleared by `rst_i` only, not by `flush_i`.
  - Reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- Package `fifo_reader_pkg`:
  - state enum `fifo_reader_state_t` {IDLE, PEND};
  - default `WIDTH`/`BUF_DEPTH` localparams;
  - stats counter width constant (32).
- Sub-module `fifo_reader_buf`: circular buffer with write/read pointers, `count`, push/pop/clear.
- Top level: FSM, strobe logic, optional counter.

## Test plan
- Reset, FIFO holds 0x11,0x22,0x33, `out_ack_i`=1 → three strobes two cycles apart; `out_dat_o` delivers 0x11,0x22,0x33 in order; each byte appears 2 edges after its strobe.
- `out_ack_i`=0, FIFO holds 4 bytes, `BUF_DEPTH`=2 → exactly two strobes, then `rd_stb_o` stays 0 with `out_dat_o`=first byte held; raising ack → the remaining bytes follow in order.
- `rd_empty_i`=1 throughout → `rd_stb_o` never asserts and `out_stb_o` stays 0.
- `flush_i` pulse in a PEND cycle, with one byte buffered → next cycle `out_stb_o`=0 and the in-flight byte never appears.
- `rst_i` asserted while `out_stb_o`=1 → after the edge, all outputs are at their reset values; with the FIFO also reset and refilled with 0xA5 → 0xA5 is delivered.
- With `FIFO_READER_STATS_EN`: 256 transfers followed by a flush → `bytes_o`=256, unchanged by the flush; `rst_i` → 0.
